// File: rtl/scan_data_register.sv
// Scan data register: captures a parallel SoC word, shifts it out while shifting a new
// word in, then latches the new word onto updateOutput and pulses done.
module scan_data_register #(
   parameter int unsigned LENGTH    = 8,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   input  logic [LENGTH-1:0] socOutput,
   input  logic              jtagInput,
   output logic              jtagOutput,
   output logic [LENGTH-1:0] updateOutput,
   output logic              busy,
   output logic              done
);

   localparam int unsigned      CNT_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [LENGTH-1:0] r_sr;
   logic [LENGTH-1:0] w_sr_nxt;
   logic [LENGTH-1:0] w_sr_shifted;
   logic [LENGTH-1:0] r_upd;
   logic [LENGTH-1:0] w_upd_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_done;
   logic              w_done_nxt;

   // One-bit shift in the configured direction; a 1-bit register simply takes the serial input.
   generate
      if (LENGTH == 1) begin : g_len1
         assign w_sr_shifted = jtagInput;
      end else if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_sr_shifted = {jtagInput, r_sr[LENGTH-1:1]};
      end else begin : g_msb_first
         assign w_sr_shifted = {r_sr[LENGTH-2:0], jtagInput};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_upd   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_upd   <= w_upd_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_upd_nxt   = r_upd;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_sr_nxt    = socOutput;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!hold) begin
               w_sr_nxt = w_sr_shifted;
               if (r_cnt == CNT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_UPDATE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_UPDATE: begin
            w_upd_nxt   = r_sr;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Serial out is the output-end bit of the shift register, not re-registered.
   assign jtagOutput   = (LSB_FIRST != 0) ? r_sr[0] : r_sr[LENGTH-1];
   assign updateOutput = r_upd;
   assign busy         = (r_state != ST_IDLE);
   assign done         = r_done;

endmodule

// File: tb/tb_scan_data_register.sv
// Self-checking bench for scan_data_register: LSB-first and MSB-first 8-bit instances plus a 1-bit instance.
module tb_scan_data_register;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]      start_v, hold_v, jin_v;
   logic [1:0][7:0] soc_v;
   logic [1:0]      jout_v, busy_v, done_v;
   logic [1:0][7:0] upd_v;
   logic            jout_l, busy_l, done_l, jout_m, busy_m, done_m;
   logic [7:0]      upd_l, upd_m;
   logic            start1, hold1, jin1, jout1, busy1, done1;
   logic [0:0]      soc1, upd1;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] obs_seq, obs_upd;
   int         obs_edges;
   bit         obs_busy_ok, obs_hold_ok, obs_e0_busy, obs_busy_done, obs_done_next, obs_busy_next;

   always #5 clk = ~clk;

   scan_data_register #(.LENGTH(8), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst(rst), .start(start_v[0]), .hold(hold_v[0]), .socOutput(soc_v[0]),
      .jtagInput(jin_v[0]), .jtagOutput(jout_l), .updateOutput(upd_l), .busy(busy_l), .done(done_l));

   scan_data_register #(.LENGTH(8), .LSB_FIRST(0)) u_msb (
      .clk(clk), .rst(rst), .start(start_v[1]), .hold(hold_v[1]), .socOutput(soc_v[1]),
      .jtagInput(jin_v[1]), .jtagOutput(jout_m), .updateOutput(upd_m), .busy(busy_m), .done(done_m));

   scan_data_register #(.LENGTH(1), .LSB_FIRST(1)) u_len1 (
      .clk(clk), .rst(rst), .start(start1), .hold(hold1), .socOutput(soc1),
      .jtagInput(jin1), .jtagOutput(jout1), .updateOutput(upd1), .busy(busy1), .done(done1));

   assign jout_v = {jout_m, jout_l};
   assign busy_v = {busy_m, busy_l};
   assign done_v = {done_m, done_l};
   assign upd_v  = {upd_m, upd_l};

   // Reference: k-th serial bit out is the k-th captured bit in shift order.
   function automatic logic [7:0] model_seq(input logic [7:0] cap, input bit lsb);
      logic [7:0] s;
      for (int k = 1; k <= 8; k++) s[k-1] = lsb ? cap[k-1] : cap[8-k];
      return s;
   endfunction

   // Reference: the k-th serial bit in lands at bit k-1 (LSB first) or bit 8-k (MSB first).
   function automatic logic [7:0] model_word(input logic [7:0] ser, input bit lsb);
      logic [7:0] w;
      for (int k = 1; k <= 8; k++) begin
         if (lsb) w[k-1] = ser[k-1];
         else     w[8-k] = ser[k-1];
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one transfer on instance sel; ser[k-1] is the k-th serial bit fed in.
   task automatic xfer(input int sel, input logic [7:0] cap, input logic [7:0] ser,
                       input int hold_after, input int hold_n, input bit poke);
      int   n;
      logic prev;
      obs_busy_ok = 1'b1; obs_hold_ok = 1'b1; obs_seq = '0; obs_upd = '0; obs_edges = -1;
      obs_busy_done = 1'b1;
      soc_v[sel]   = cap;
      start_v[sel] = 1'b1;
      tick();
      start_v[sel] = 1'b0;
      obs_e0_busy  = busy_v[sel];
      n = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k - 1 == hold_after) begin
            prev        = jout_v[sel];
            hold_v[sel] = 1'b1;
            for (int h = 0; h < hold_n; h++) begin
               start_v[sel] = poke && (h == 0);
               jin_v[sel]   = 1'($urandom);
               tick(); n++;
               if (!busy_v[sel] || done_v[sel]) obs_busy_ok = 1'b0;
               if (jout_v[sel] !== prev) obs_hold_ok = 1'b0;
            end
            hold_v[sel]  = 1'b0;
            start_v[sel] = 1'b0;
         end
         jin_v[sel]     = ser[k-1];
         obs_seq[k-1]   = jout_v[sel];
         tick(); n++;
         if (!busy_v[sel] || done_v[sel]) obs_busy_ok = 1'b0;
      end
      for (int i = 0; i < 6 && obs_edges < 0; i++) begin
         tick(); n++;
         if (done_v[sel]) begin
            obs_edges     = n;
            obs_upd       = upd_v[sel];
            obs_busy_done = busy_v[sel];
         end
      end
      tick();
      obs_done_next = done_v[sel];
      obs_busy_next = busy_v[sel];
   endtask

   task automatic test_reset();
      rst = 1'b0; soc_v = {8'h84, 8'h84}; start_v = 2'b11; soc1 = 1'b1; start1 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_vec++;
         if ({jout_l, upd_l, busy_l, done_l} !== 11'd0) begin
            n_err++; $display("FAIL reset_lsb: got %h want 0", {jout_l, upd_l, busy_l, done_l});
         end
         n_vec++;
         if ({jout_m, upd_m, busy_m, done_m} !== 11'd0) begin
            n_err++; $display("FAIL reset_msb: got %h want 0", {jout_m, upd_m, busy_m, done_m});
         end
         n_vec++;
         if ({jout1, upd1, busy1, done1} !== 4'd0) begin
            n_err++; $display("FAIL reset_len1: got %h want 0", {jout1, upd1, busy1, done1});
         end
      end
      start_v = 2'b00; start1 = 1'b0;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_vec++;
         if ({busy_v, done_v, upd_l, jout_l} !== 13'd0) begin
            n_err++; $display("FAIL idle_after_reset: got %h want 0", {busy_v, done_v, upd_l, jout_l});
         end
      end
   endtask

   task automatic test_basic_lsb();
      xfer(0, 8'h53, 8'hA5, 99, 0, 1'b0);
      n_vec++; if (obs_e0_busy !== 1'b1) begin n_err++; $display("FAIL lsb_e0_busy: got %b want 1", obs_e0_busy); end
      n_vec++; if (obs_seq !== 8'h53) begin n_err++; $display("FAIL lsb_jtag_seq: got %h want 53", obs_seq); end
      n_vec++; if (obs_busy_ok !== 1'b1) begin n_err++; $display("FAIL lsb_busy_shift: got %b want 1", obs_busy_ok); end
      n_vec++; if (obs_edges !== 9) begin n_err++; $display("FAIL lsb_done_edge: got %0d want 9", obs_edges); end
      n_vec++; if (obs_upd !== 8'hA5) begin n_err++; $display("FAIL lsb_update: got %h want a5", obs_upd); end
      n_vec++; if (obs_busy_done !== 1'b0) begin n_err++; $display("FAIL lsb_busy_done: got %b want 0", obs_busy_done); end
      n_vec++; if (obs_done_next !== 1'b0) begin n_err++; $display("FAIL lsb_done_width: got %b want 0", obs_done_next); end
   endtask

   task automatic test_msb_first();
      xfer(1, 8'h53, 8'hA5, 99, 0, 1'b0);
      n_vec++; if (obs_seq !== 8'hCA) begin n_err++; $display("FAIL msb_jtag_seq: got %h want ca", obs_seq); end
      n_vec++; if (obs_edges !== 9) begin n_err++; $display("FAIL msb_done_edge: got %0d want 9", obs_edges); end
      n_vec++; if (obs_upd !== 8'hA5) begin n_err++; $display("FAIL msb_update: got %h want a5", obs_upd); end
      n_vec++; if (obs_done_next !== 1'b0) begin n_err++; $display("FAIL msb_done_width: got %b want 0", obs_done_next); end
   endtask

   task automatic test_hold_start();
      bit quiet;
      xfer(0, 8'h53, 8'hA5, 3, 3, 1'b1);
      n_vec++; if (obs_seq !== 8'h53) begin n_err++; $display("FAIL hold_jtag_seq: got %h want 53", obs_seq); end
      n_vec++; if (obs_hold_ok !== 1'b1) begin n_err++; $display("FAIL hold_frozen: got %b want 1", obs_hold_ok); end
      n_vec++; if (obs_edges !== 12) begin n_err++; $display("FAIL hold_done_edge: got %0d want 12", obs_edges); end
      n_vec++; if (obs_upd !== 8'hA5) begin n_err++; $display("FAIL hold_update: got %h want a5", obs_upd); end
      n_vec++; if (obs_busy_next !== 1'b0) begin n_err++; $display("FAIL hold_no_requeue: got %b want 0", obs_busy_next); end
      quiet = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (busy_l || done_l) quiet = 1'b0;
      end
      n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL hold_second_xfer: got %b want 1", quiet); end
   endtask

   task automatic test_random();
      logic [7:0] cap, ser;
      int         sel, ha, hn;
      bit         poke;
      for (int i = 0; i < 12; i++) begin
         sel = i % 2; cap = 8'($urandom); ser = 8'($urandom);
         ha = $urandom_range(0, 7); hn = $urandom_range(0, 3); poke = 1'($urandom);
         xfer(sel, cap, ser, ha, hn, poke);
         n_vec++;
         if (obs_seq !== model_seq(cap, sel == 0)) begin
            n_err++; $display("FAIL rand_seq[%0d]: got %h want %h", i, obs_seq, model_seq(cap, sel == 0));
         end
         n_vec++;
         if (obs_upd !== model_word(ser, sel == 0)) begin
            n_err++; $display("FAIL rand_update[%0d]: got %h want %h", i, obs_upd, model_word(ser, sel == 0));
         end
         n_vec++;
         if (obs_edges !== 9 + hn) begin
            n_err++; $display("FAIL rand_done_edge[%0d]: got %0d want %0d", i, obs_edges, 9 + hn);
         end
         n_vec++;
         if ({obs_busy_ok, obs_hold_ok, obs_done_next} !== 3'b110) begin
            n_err++; $display("FAIL rand_flags[%0d]: got %b want 110", i, {obs_busy_ok, obs_hold_ok, obs_done_next});
         end
      end
   endtask

   task automatic test_reset_mid();
      bit quiet;
      xfer(0, 8'h11, 8'h3C, 99, 0, 1'b0);
      n_vec++; if (obs_upd !== 8'h3C) begin n_err++; $display("FAIL rmid_prev_update: got %h want 3c", obs_upd); end
      soc_v[0] = 8'hFF; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0; jin_v[0] = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b0;
      #1;
      n_vec++;
      if ({jout_l, upd_l, busy_l, done_l} !== 11'd0) begin
         n_err++; $display("FAIL rmid_async_clear: got %h want 0", {jout_l, upd_l, busy_l, done_l});
      end
      quiet = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done_l || busy_l || upd_l != 8'h00) quiet = 1'b0;
      end
      n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL rmid_no_done: got %b want 1", quiet); end
      rst = 1'b1;
      tick();
      xfer(0, 8'hC3, 8'h69, 99, 0, 1'b0);
      n_vec++; if (obs_seq !== model_seq(8'hC3, 1'b1)) begin n_err++; $display("FAIL rmid_seq: got %h want c3", obs_seq); end
      n_vec++; if (obs_upd !== 8'h69) begin n_err++; $display("FAIL rmid_update: got %h want 69", obs_upd); end
      n_vec++; if (obs_edges !== 9) begin n_err++; $display("FAIL rmid_done_edge: got %0d want 9", obs_edges); end
   endtask

   task automatic test_back_to_back();
      int dones[$];
      start_v[0] = 1'b1;
      for (int c = 0; c < 45; c++) begin
         soc_v[0] = 8'($urandom); jin_v[0] = 1'($urandom);
         tick();
         if (done_l) dones.push_back(c);
      end
      start_v[0] = 1'b0;
      for (int c = 0; c < 12; c++) tick();
      n_vec++; if (dones.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", dones.size()); end
      if (dones.size() > 0) begin
         n_vec++; if (dones[0] !== 9) begin n_err++; $display("FAIL b2b_first: got %0d want 9", dones[0]); end
      end
      for (int i = 1; i < dones.size(); i++) begin
         n_vec++;
         if (dones[i] - dones[i-1] !== 10) begin
            n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 10", i, dones[i] - dones[i-1]);
         end
      end
   endtask

   task automatic test_len1();
      logic [1:0] cases [2];
      cases[0] = 2'b01;  // soc=0, jin=1
      cases[1] = 2'b10;  // soc=1, jin=0
      for (int i = 0; i < 2; i++) begin
         soc1 = cases[i][1]; jin1 = cases[i][0]; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         n_vec++;
         if ({jout1, busy1} !== {cases[i][1], 1'b1}) begin
            n_err++; $display("FAIL len1_e0[%0d]: got %b want %b", i, {jout1, busy1}, {cases[i][1], 1'b1});
         end
         tick();
         n_vec++;
         if ({jout1, busy1, done1} !== {cases[i][0], 2'b10}) begin
            n_err++; $display("FAIL len1_e1[%0d]: got %b want %b", i, {jout1, busy1, done1}, {cases[i][0], 2'b10});
         end
         tick();
         n_vec++;
         if ({upd1, busy1, done1} !== {cases[i][0], 2'b01}) begin
            n_err++; $display("FAIL len1_e2[%0d]: got %b want %b", i, {upd1, busy1, done1}, {cases[i][0], 2'b01});
         end
         tick();
         n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL len1_done_width[%0d]: got %b want 0", i, done1); end
      end
   endtask

   initial begin
      rst = 1'b0; start_v = '0; hold_v = '0; jin_v = '0; soc_v = '0;
      start1 = 1'b0; hold1 = 1'b0; jin1 = 1'b0; soc1 = '0;
      test_reset();
      test_basic_lsb();
      test_msb_first();
      test_hold_start();
      test_random();
      test_reset_mid();
      test_back_to_back();
      test_len1();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
